// File: rtl/mms_stream_if.sv
// mms_stream_if -- handshake bundle for the serial min/max stream block.
//   Input side : in_valid/in_ready handshake carrying number, in_last, select.
//   Output side: out_valid/out_ready handshake carrying result, count, trunc.
// slave  = the mms_stream block itself; master = the source/consumer driving it.
interface mms_stream_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] number;
  logic       in_last;
  logic       select;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] count;
  logic       trunc;

  modport slave (
    input  in_valid, number, in_last, select, out_ready,
    output in_ready, out_valid, result, count, trunc
  );

  modport master (
    output in_valid, number, in_last, select, out_ready,
    input  in_ready, out_valid, result, count, trunc
  );
endinterface

// File: rtl/mms_stream.sv
// mms_stream -- serial min/max over a group of 8-bit beats.
//   clk : single clock, rising edge
//   rst : asynchronous, active-high reset
//   s   : mms_stream_if.slave
//         in_*  : one operand per accepted beat; select (1=min, 0=max) is
//                 taken from the first beat of a group only
//         out_* : one result per group: result, beat count, and trunc when
//                 the group was closed by reaching MAX_LEN beats
// A group closes on in_last or on its MAX_LEN-th beat. While the result is
// waiting for out_ready the input side is stalled (in_ready = 0).
module mms_stream #(
  parameter int MAX_LEN = 8
) (
  input  logic         clk,
  input  logic         rst,
  mms_stream_if.slave  s
);
  localparam logic [3:0] MAX_CNT = 4'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic       sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic       trunc_q, trunc_d;

  logic       accept;
  logic       take_new;
  logic [3:0] cnt_inc;

  assign s.in_ready = (state_q != DONE);
  assign accept     = s.in_valid & s.in_ready;
  assign cnt_inc    = cnt_q + 4'd1;
  // Strict compare keeps acc on ties; the value is the same either way.
  assign take_new   = sel_q ? (s.number < acc_q) : (s.number > acc_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    case (state_q)
      IDLE: if (accept) begin
        acc_d   = s.number;
        sel_d   = s.select;
        cnt_d   = 4'd1;
        trunc_d = 1'b0;
        state_d = s.in_last ? DONE : ACC;
      end
      ACC: if (accept) begin
        cnt_d = cnt_inc;
        if (take_new) acc_d = s.number;
        // in_last wins over the length limit: a final beat landing exactly
        // on MAX_LEN is a normal close, not a truncation.
        if (s.in_last) begin
          state_d = DONE;
          trunc_d = 1'b0;
        end else if (cnt_inc == MAX_CNT) begin
          state_d = DONE;
          trunc_d = 1'b1;
        end
      end
      DONE: if (s.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 8'd0;
      sel_q   <= 1'b0;
      cnt_q   <= 4'd0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  // Result fields are only meaningful in DONE; force them to zero elsewhere
  // so a consumer never sees stale group data.
  assign s.out_valid = (state_q == DONE);
  assign s.result    = s.out_valid ? acc_q   : 8'd0;
  assign s.count     = s.out_valid ? cnt_q   : 4'd0;
  assign s.trunc     = s.out_valid ? trunc_q : 1'b0;
endmodule

// File: tb/tb_mms_stream.sv
// tb_mms_stream -- directed plus randomized bench for mms_stream.
// All driving and sampling happens on the falling clock edge.
module tb_mms_stream;
  localparam int MAX_LEN = 8;

  logic clk;
  logic rst;
  int   n_tot  = 0;
  int   n_pass = 0;

  mms_stream_if ifc ();

  mms_stream #(.MAX_LEN(MAX_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .s   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic timeout(input string tag);
    n_tot++;
    $error("FAIL %s: timed out waiting on DUT", tag);
  endtask

  // Offer one beat and return on the falling edge after it was accepted.
  task automatic beat(input logic [7:0] n, input logic l, input logic s);
    int t;
    ifc.in_valid = 1'b1;
    ifc.number   = n;
    ifc.in_last  = l;
    ifc.select   = s;
    t = 0;
    while (ifc.in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout("beat_accept");
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    ifc.number   = 8'h00;
  endtask

  // Wait for the result, compare it, consume it, and check it clears.
  task automatic take(input string tag, input logic [7:0] r, input int c, input logic tr);
    int t;
    t = 0;
    while (ifc.out_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout({tag, "_valid"});
    chk({tag, "_result"}, ifc.result, r);
    chk({tag, "_count"},  ifc.count, c);
    chk({tag, "_trunc"},  ifc.trunc, tr);
    ifc.out_ready = 1'b1;
    @(negedge clk);
    ifc.out_ready = 1'b0;
    chk({tag, "_clear"}, {ifc.out_valid, ifc.result, ifc.count, ifc.trunc}, 0);
  endtask

  // Reference: min or max of the beats, computed directly from the queue.
  function automatic logic [7:0] ref_sel(input logic [7:0] q[$], input logic mn);
    logic [7:0] r;
    r = q[0];
    foreach (q[i]) begin
      if (mn  && q[i] < r) r = q[i];
      if (!mn && q[i] > r) r = q[i];
    end
    return r;
  endfunction

  initial begin
    logic [7:0] q[$];
    logic [7:0] n;
    logic       sel, tr, lst;
    int         len;

    ifc.in_valid  = 1'b0;
    ifc.number    = 8'h00;
    ifc.in_last   = 1'b0;
    ifc.select    = 1'b0;
    ifc.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_outs", {ifc.out_valid, ifc.result, ifc.count, ifc.trunc}, 0);
    rst = 1'b0;
    @(negedge clk);

    // min of four, consumer always ready, latency one cycle
    ifc.out_ready = 1'b1;
    beat(8'h20, 0, 1); beat(8'h05, 0, 1); beat(8'hF0, 0, 1); beat(8'h05, 1, 1);
    chk("r34_valid",  ifc.out_valid, 1);
    chk("r34_result", ifc.result, 8'h05);
    chk("r34_count",  ifc.count, 4);
    chk("r34_trunc",  ifc.trunc, 0);
    @(negedge clk);
    chk("r34_clear", ifc.out_valid, 0);
    ifc.out_ready = 1'b0;

    // unsigned max, select toggled on beat 2 ignored
    beat(8'h7F, 0, 0); beat(8'h80, 1, 1);
    chk("r35_latency", ifc.out_valid, 1);
    take("r35", 8'h80, 2, 0);

    // truncation at MAX_LEN, ninth beat held then opens the next group
    for (int i = 1; i <= MAX_LEN; i++) beat(8'(i), 0, 0);
    chk("r36_valid", ifc.out_valid, 1);
    ifc.in_valid = 1'b1; ifc.number = 8'h09; ifc.in_last = 1'b0; ifc.select = 1'b0;
    repeat (2) begin
      chk("r36_held_ready", ifc.in_ready, 0);
      chk("r36_held_res",   ifc.result, MAX_LEN);
      @(negedge clk);
    end
    take("r36", 8'(MAX_LEN), MAX_LEN, 1);
    beat(8'h09, 0, 0); beat(8'h02, 1, 0);
    take("r36_next", 8'h09, 2, 0);

    // in_last on the MAX_LEN-th beat is not a truncation
    for (int i = 1; i <= MAX_LEN; i++) beat(8'(40 - i), i == MAX_LEN, 1);
    take("r22", 8'(40 - MAX_LEN), MAX_LEN, 0);

    // single beat, stalled consumer
    beat(8'h33, 1, 0);
    repeat (5) begin
      chk("r37_valid", ifc.out_valid, 1);
      chk("r37_stable", {ifc.result, ifc.count, ifc.in_ready}, {8'h33, 4'd1, 1'b0});
      @(negedge clk);
    end
    take("r37", 8'h33, 1, 0);

    // async reset mid-group and in DONE
    beat(8'h40, 0, 1); beat(8'h41, 0, 1); beat(8'h42, 0, 1);
    #2 rst = 1'b1;
    #1 chk("r38_mid_ready", ifc.in_ready, 1);
    chk("r38_mid_outs", {ifc.out_valid, ifc.result, ifc.count, ifc.trunc}, 0);
    @(negedge clk); rst = 1'b0;
    beat(8'h55, 1, 0);
    chk("r38_done_valid", ifc.out_valid, 1);
    #2 rst = 1'b1;
    #1 chk("r38_done_outs", {ifc.out_valid, ifc.result, ifc.count, ifc.trunc, ifc.in_ready}, 1);
    @(negedge clk); rst = 1'b0;
    beat(8'h10, 1, 1);
    take("r38_after", 8'h10, 1, 0);

    // random groups with random input gaps and mid-group select noise
    for (int g = 0; g < 30; g++) begin
      len = $urandom_range(1, MAX_LEN);
      tr  = (len == MAX_LEN) && ($urandom_range(0, 1) == 1);
      sel = 1'($urandom_range(0, 1));
      q.delete();
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        n   = 8'($urandom);
        lst = (i == len - 1) && !tr;
        q.push_back(n);
        beat(n, lst, (i == 0) ? sel : 1'($urandom_range(0, 1)));
      end
      chk("rnd_latency", ifc.out_valid, 1);
      take("rnd", ref_sel(q, sel), len, tr);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
